cordic_post_proc: RTL
=====================

CORDIC_POST_PROC -- requirements
Module: cordic_post_proc

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- NUM_DATA, 3, data lanes (X=2, Y=1, Z=0).
- FUNC_WIDTH, 1, function tag width.
- DATA_OP_WIDTH, 18, input lane width (signed).
- DATA_WIDTH, 16, output lane width (signed).
- EN_SCALE, 1, 1 = apply CORDIC gain compensation to X and Y; 0 = bypass.
- FIFO_DEPTH, 4, output FIFO entries (power of 2, >=2).
REQ-002 Ports, one per line: name, direction, width, meaning.
- i_clk, in, 1, sole clock, rising edge.
- i_rst, in, 1, reset: synchronous, active-high.
- i_vld, in, 1, input word valid; no backpressure to upstream.
- i_data, in, NUM_DATA*DATA_OP_WIDTH+FUNC_WIDTH, {func, X, Y, Z}, func in MSBs.
- o_vld, out, 1, output FIFO head valid.
- i_rdy, in, 1, downstream ready; pop when o_vld&&i_rdy.
- o_data, out, NUM_DATA*DATA_WIDTH+FUNC_WIDTH, {func, X, Y, Z} at FIFO head.
- o_ovf, out, 1, sticky: word dropped because FIFO full.
- i_ovf_clr, in, 1, clears o_ovf.
- o_sat, out, 1, sticky: any lane saturated since reset.

Function
REQ-003 Stage 1 SHALL register i_vld, func, Z, and the products X*K, Y*K (K=19898, Q15 of 0.607253) when EN_SCALE=1; raw X, Y when EN_SCALE=0.
REQ-004 Scaled lanes: stage 2 SHALL add 2^14 to the product, arithmetic-shift right 15 (round half up).
REQ-005 All lanes SHALL saturate to DATA_WIDTH signed: >32767 -> 32767, <-32768 -> -32768; otherwise truncate to low DATA_WIDTH bits.
REQ-006 Stage 2 SHALL register the saturated word plus valid; the word SHALL be written into the FIFO on the next edge when valid.
REQ-007 Latency: word sampled at edge N SHALL be written to the FIFO at edge N+2; with FIFO empty, o_vld=1 and o_data valid after edge N+2.
REQ-008 Pipeline SHALL accept one word per cycle, back-to-back, independent of i_rdy.
REQ-009 FIFO: first-word-fall-through; o_data SHALL be stable while o_vld=1 and i_rdy=0.
REQ-010 Pop SHALL occur on an edge where o_vld=1 and i_rdy=1; i_rdy with FIFO empty SHALL have no effect.
REQ-011 Full FIFO plus write plus pop in the same cycle: both SHALL occur; occupancy unchanged, no drop.
REQ-012 Full FIFO plus write without pop: write SHALL be discarded, FIFO contents unchanged, o_ovf=1 from the next edge.
REQ-013 Empty FIFO plus write plus i_rdy: no bypass; the word SHALL appear on o_vld the cycle after the write.
REQ-014 Read/write pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter range 0..FIFO_DEPTH.
REQ-015 o_ovf: i_ovf_clr clears it next edge; a drop coinciding with clear SHALL leave o_ovf=1 (set wins).
REQ-016 o_sat SHALL set the edge after any valid stage-2 word saturated a lane; cleared only by reset.
REQ-017 func SHALL pass unchanged, aligned with its data.

Reset
REQ-018 i_rst high at an edge SHALL clear pipeline valids, FIFO pointers, and occupancy; o_vld=0, o_ovf=0, o_sat=0, o_data=0.
REQ-019 Words in flight or in the FIFO at reset SHALL be lost; no output until new input after reset deasserts.
REQ-020 Data registers need not reset beyond o_data=0; valid bits SHALL.

Verification
REQ-021 EN_SCALE=1, X=16384, Y=-16384, Z=100, func=1, i_rdy=1 -> after 2 edges o_data={1, 9949, -9949, 100}, o_vld for one cycle.
REQ-022 EN_SCALE=0, X=60000, Y=-60000, Z=-40000 -> {32767, -32768, -32768}, o_sat=1.
REQ-023 i_rdy=0, 6 consecutive valid words, FIFO_DEPTH=4 -> first 4 retained in order, words 5 and 6 dropped, o_ovf=1; then i_rdy=1 -> exactly 4 pops.
REQ-024 FIFO full, i_vld=1 and i_rdy=1 each cycle for 8 cycles -> no drops, o_ovf stays 0, order preserved across pointer wrap.
REQ-025 Drop in same cycle as i_ovf_clr -> o_ovf remains 1; clear alone next cycle -> o_ovf=0.
REQ-026 Reset asserted with 3 words queued and 2 in the pipeline -> o_vld=0 next cycle, nothing emitted afterwards until new input arrives.

Source files
------------

// File: rtl/cordic_post_proc.sv
// rtl/cordic_post_proc.sv - CORDIC output gain compensation, lane saturation and FWFT output FIFO
module cordic_post_proc #(
  parameter int NUM_DATA      = 3,
  parameter int FUNC_WIDTH    = 1,
  parameter int DATA_OP_WIDTH = 18,
  parameter int DATA_WIDTH    = 16,
  parameter int EN_SCALE      = 1,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                                         i_clk,
  input  logic                                         i_rst,
  input  logic                                         i_vld,
  input  logic [NUM_DATA*DATA_OP_WIDTH+FUNC_WIDTH-1:0] i_data,
  output logic                                         o_vld,
  input  logic                                         i_rdy,
  output logic [NUM_DATA*DATA_WIDTH+FUNC_WIDTH-1:0]    o_data,
  output logic                                         o_ovf,
  input  logic                                         i_ovf_clr,
  output logic                                         o_sat
);
  localparam int OW = NUM_DATA*DATA_WIDTH+FUNC_WIDTH;
  localparam int PW = DATA_OP_WIDTH + 16;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic signed [PW-1:0] SCALE_K = PW'(19898);
  localparam logic signed [PW-1:0] ROUND   = PW'(1 << 14);
  localparam logic signed [PW-1:0] SAT_MAX = {{(PW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_MIN = {{(PW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  logic signed [DATA_OP_WIDTH-1:0] in_lane [NUM_DATA];
  logic signed [PW-1:0]            s1_lane [NUM_DATA];
  logic signed [PW-1:0]            s2_pre  [NUM_DATA];
  logic                            s1_vld;
  logic [FUNC_WIDTH-1:0]           s1_func;
  logic [OW-1:0]                   s2_word_d;
  logic                            s2_sat_d;
  logic                            s2_vld;
  logic                            s2_sat;
  logic [OW-1:0]                   s2_word;

  logic [OW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;

  always_comb begin
    for (int i = 0; i < NUM_DATA; i++) begin
      in_lane[i] = i_data[i*DATA_OP_WIDTH +: DATA_OP_WIDTH];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) s1_vld <= 1'b0;
    else       s1_vld <= i_vld;
  end

  // Lane 0 is Z (angle) and is never gain-compensated.
  always_ff @(posedge i_clk) begin
    s1_func <= i_data[NUM_DATA*DATA_OP_WIDTH +: FUNC_WIDTH];
    for (int i = 0; i < NUM_DATA; i++) begin
      if (i != 0 && EN_SCALE != 0) s1_lane[i] <= PW'(in_lane[i]) * SCALE_K;
      else                         s1_lane[i] <= PW'(in_lane[i]);
    end
  end

  always_comb begin
    s2_word_d = '0;
    s2_sat_d  = 1'b0;
    s2_word_d[OW-1 -: FUNC_WIDTH] = s1_func;
    for (int i = 0; i < NUM_DATA; i++) begin
      if (i != 0 && EN_SCALE != 0) s2_pre[i] = (s1_lane[i] + ROUND) >>> 15;
      else                         s2_pre[i] = s1_lane[i];
      if (s2_pre[i] > SAT_MAX) begin
        s2_word_d[i*DATA_WIDTH +: DATA_WIDTH] = SAT_MAX[DATA_WIDTH-1:0];
        s2_sat_d = 1'b1;
      end else if (s2_pre[i] < SAT_MIN) begin
        s2_word_d[i*DATA_WIDTH +: DATA_WIDTH] = SAT_MIN[DATA_WIDTH-1:0];
        s2_sat_d = 1'b1;
      end else begin
        s2_word_d[i*DATA_WIDTH +: DATA_WIDTH] = s2_pre[i][DATA_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) s2_vld <= 1'b0;
    else       s2_vld <= s1_vld;
  end

  always_ff @(posedge i_clk) begin
    s2_word <= s2_word_d;
    s2_sat  <= s2_sat_d;
  end

  // A full FIFO still accepts a write when the head is popped on the same edge.
  always_comb begin
    full = (count == (AW+1)'(FIFO_DEPTH));
    pop  = o_vld & i_rdy;
    push = s2_vld & (~full | pop);
    drop = s2_vld & full & ~pop;
  end

  assign o_vld  = (count != '0);
  assign o_data = o_vld ? mem[rd_ptr] : '0;

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= s2_word;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_ovf <= 1'b0;
      o_sat <= 1'b0;
    end else begin
      if (drop)           o_ovf <= 1'b1;
      else if (i_ovf_clr) o_ovf <= 1'b0;
      if (s2_vld && s2_sat) o_sat <= 1'b1;
    end
  end
endmodule
